execute_muldiv: RTL and testbench

Iterative multiply/divide execute unit for the MIPS pipeline, sitting beside the single-cycle execute ALU and fed from the same decode outputs. It executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO against private HI/LO registers, parametrised in data width. It stalls the front end while a multi-cycle operation is in flight.

---
 rtl/execute_muldiv_pkg.sv | 44 ++++
 rtl/execute_muldiv_iter.sv | 65 ++++++
 rtl/execute_muldiv.sv | 159 +++++++++++++++
 tb/tb_execute_muldiv.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_muldiv_pkg.sv
// Shared opcode/funct encodings and control types for the iterative HI/LO multiply/divide unit.
// MIPS R-type functs are decoded here so decode and execute agree on one table.
package execute_muldiv_pkg;

   localparam int OPCODE_WIDTH = 6;
   localparam int FUNCT_WIDTH  = 6;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;

   localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD   = 6'h20;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB   = 6'h22;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFHI  = 6'h10;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTHI  = 6'h11;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFLO  = 6'h12;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTLO  = 6'h13;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULT  = 6'h18;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULTU = 6'h19;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIV   = 6'h1A;
   localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIVU  = 6'h1B;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   // Captured at accept and consumed in FIX to turn magnitude results into HI/LO.
   typedef struct packed {
      logic is_div;
      logic prod_neg;
      logic rem_neg;
      logic div_zero;
   } fix_ctl_t;

   function automatic logic is_hilo_funct(input logic [FUNCT_WIDTH-1:0] funct);
      logic hit;
      case (funct)
         FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
         FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: hit = 1'b1;
         default:                                         hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/execute_muldiv_iter.sv
// Shared iterative datapath: radix-2 shift-add multiply and restoring divide on unsigned magnitudes.
// {acc, sreg} holds the product after a multiply, or remainder/quotient after a divide.
module muldiv_iter #(
   parameter int DWIDTH    = 32,
   parameter int CNT_WIDTH = $clog2(DWIDTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic              is_div,
   input  logic [DWIDTH-1:0] op_a,
   input  logic [DWIDTH-1:0] op_b,
   output logic [DWIDTH-1:0] acc,
   output logic [DWIDTH-1:0] sreg,
   output logic              last
);

   logic [DWIDTH-1:0]    operand;
   logic [CNT_WIDTH-1:0] count;
   logic [DWIDTH:0]      mul_sum;
   logic [DWIDTH:0]      div_shift;
   logic [DWIDTH:0]      div_diff;
   logic                 div_ge;

   always_comb begin
      mul_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : '0);
      div_shift = {acc, sreg[DWIDTH-1]};
      div_diff  = div_shift - {1'b0, operand};
      div_ge    = (div_shift >= {1'b0, operand});
   end

   assign last = (count == '0);

   // op_a is the multiplicand/divisor, op_b seeds the shift register (multiplier/dividend).
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc     <= '0;
         sreg    <= '0;
         operand <= '0;
         count   <= '0;
      end else if (start) begin
         acc     <= '0;
         sreg    <= op_b;
         operand <= op_a;
         count   <= CNT_WIDTH'(DWIDTH - 1);
      end else if (step) begin
         if (is_div) begin
            if (div_ge) begin
               acc  <= div_diff[DWIDTH-1:0];
               sreg <= {sreg[DWIDTH-2:0], 1'b1};
            end else begin
               acc  <= div_shift[DWIDTH-1:0];
               sreg <= {sreg[DWIDTH-2:0], 1'b0};
            end
         end else begin
            {acc, sreg} <= {mul_sum, sreg[DWIDTH-1:1]};
         end
         if (!last) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/execute_muldiv.sv
// HI/LO multiply/divide execute unit: accepts MULT/DIV/MFHI/MFLO/MTHI/MTLO from decode,
// runs the iterative datapath and stalls the front end until the result lands in HI/LO.
module execute_muldiv
   import execute_muldiv_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int CNT_WIDTH = $clog2(DWIDTH) + 1
) (
   input  logic                    es_clk,
   input  logic                    es_rst,
   input  logic                    es_i_ce,
   input  logic [OPCODE_WIDTH-1:0] es_i_alu_op,
   input  logic [FUNCT_WIDTH-1:0]  es_i_alu_funct,
   input  logic [DWIDTH-1:0]       es_i_data_rs,
   input  logic [DWIDTH-1:0]       es_i_data_rt,
   output logic                    es_o_stall,
   output logic [DWIDTH-1:0]       es_o_alu_value,
   output logic                    es_o_ce,
   output logic                    es_o_done
);

   logic [1:0]          state;
   fix_ctl_t            fix_ctl;
   logic [DWIDTH-1:0]   hi;
   logic [DWIDTH-1:0]   lo;
   logic [DWIDTH-1:0]   rs_raw;
   logic                accept;
   logic                is_mul_op;
   logic                is_div_op;
   logic                is_signed;
   logic                start;
   logic                rs_neg;
   logic                rt_neg;
   logic [DWIDTH-1:0]   rs_mag;
   logic [DWIDTH-1:0]   rt_mag;
   logic [DWIDTH-1:0]   iter_a;
   logic [DWIDTH-1:0]   iter_b;
   logic                step;
   logic                step_div;
   logic [DWIDTH-1:0]   acc;
   logic [DWIDTH-1:0]   sreg;
   logic                last;
   logic [2*DWIDTH-1:0] product;
   logic [2*DWIDTH-1:0] product_fixed;
   logic [DWIDTH-1:0]   quotient;
   logic [DWIDTH-1:0]   remainder;

   // Decode and operand magnitudes; signs are only honoured for MULT and DIV.
   always_comb begin
      accept    = es_i_ce && (es_i_alu_op == OP_RTYPE) &&
                  is_hilo_funct(es_i_alu_funct) && (state == ST_IDLE);
      is_mul_op = (es_i_alu_funct == FUNCT_MULT) || (es_i_alu_funct == FUNCT_MULTU);
      is_div_op = (es_i_alu_funct == FUNCT_DIV)  || (es_i_alu_funct == FUNCT_DIVU);
      is_signed = (es_i_alu_funct == FUNCT_MULT) || (es_i_alu_funct == FUNCT_DIV);
      start     = accept && (is_mul_op || is_div_op);
      rs_neg    = is_signed && es_i_data_rs[DWIDTH-1];
      rt_neg    = is_signed && es_i_data_rt[DWIDTH-1];
      rs_mag    = rs_neg ? -es_i_data_rs : es_i_data_rs;
      rt_mag    = rt_neg ? -es_i_data_rt : es_i_data_rt;
      iter_a    = is_div_op ? rt_mag : rs_mag;
      iter_b    = is_div_op ? rs_mag : rt_mag;
      step      = (state == ST_MUL) || (state == ST_DIV);
      step_div  = (state == ST_DIV);
   end

   muldiv_iter #(
      .DWIDTH    (DWIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_iter (
      .clk    (es_clk),
      .rst    (es_rst),
      .start  (start),
      .step   (step),
      .is_div (step_div),
      .op_a   (iter_a),
      .op_b   (iter_b),
      .acc    (acc),
      .sreg   (sreg),
      .last   (last)
   );

   // Sign correction; most-negative / -1 falls out naturally since its magnitude fits unsigned.
   always_comb begin
      product       = {acc, sreg};
      product_fixed = fix_ctl.prod_neg ? -product : product;
      quotient      = fix_ctl.prod_neg ? -sreg : sreg;
      remainder     = fix_ctl.rem_neg ? -acc : acc;
   end

   assign es_o_stall = (state != ST_IDLE);

   always_ff @(posedge es_clk) begin
      if (!es_rst) begin
         state          <= ST_IDLE;
         fix_ctl        <= '0;
         hi             <= '0;
         lo             <= '0;
         rs_raw         <= '0;
         es_o_alu_value <= '0;
         es_o_ce        <= 1'b0;
         es_o_done      <= 1'b0;
      end else begin
         es_o_ce   <= 1'b0;
         es_o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (es_i_alu_funct)
                     FUNCT_MULT, FUNCT_MULTU: begin
                        state   <= ST_MUL;
                        fix_ctl <= '{is_div: 1'b0, prod_neg: rs_neg ^ rt_neg,
                                     rem_neg: 1'b0, div_zero: 1'b0};
                     end
                     FUNCT_DIV, FUNCT_DIVU: begin
                        state   <= ST_DIV;
                        rs_raw  <= es_i_data_rs;
                        fix_ctl <= '{is_div: 1'b1, prod_neg: rs_neg ^ rt_neg,
                                     rem_neg: rs_neg, div_zero: (es_i_data_rt == '0)};
                     end
                     FUNCT_MTHI: hi <= es_i_data_rs;
                     FUNCT_MTLO: lo <= es_i_data_rs;
                     FUNCT_MFHI: begin
                        es_o_alu_value <= hi;
                        es_o_ce        <= 1'b1;
                     end
                     FUNCT_MFLO: begin
                        es_o_alu_value <= lo;
                        es_o_ce        <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL, ST_DIV: begin
               if (last) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               state     <= ST_IDLE;
               es_o_done <= 1'b1;
               if (fix_ctl.is_div) begin
                  if (fix_ctl.div_zero) begin
                     hi <= rs_raw;
                     lo <= '1;
                  end else begin
                     hi <= remainder;
                     lo <= quotient;
                  end
               end else begin
                  {hi, lo} <= product_fixed;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: vector table of MULT/DIV cases read back via MFHI/MFLO
// through a scoreboard queue, plus hand-written stall, reset-abort and back-to-back sequences.
module tb_execute_muldiv;
   import execute_muldiv_pkg::*;

   localparam int DW = 32;

   logic                    es_clk;
   logic                    es_rst;
   logic                    es_i_ce;
   logic [OPCODE_WIDTH-1:0] es_i_alu_op;
   logic [FUNCT_WIDTH-1:0]  es_i_alu_funct;
   logic [DW-1:0]           es_i_data_rs;
   logic [DW-1:0]           es_i_data_rt;
   logic                    es_o_stall;
   logic [DW-1:0]           es_o_alu_value;
   logic                    es_o_ce;
   logic                    es_o_done;

   typedef struct {
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   vec_t        vecs[$];
   string       expNameQ[$];
   logic [31:0] expValQ[$];
   int          errors = 0;
   int          checks = 0;
   int          doneCount = 0;
   int          ceCount = 0;

   execute_muldiv #(.DWIDTH(DW)) dut (
      .es_clk         (es_clk),
      .es_rst         (es_rst),
      .es_i_ce        (es_i_ce),
      .es_i_alu_op    (es_i_alu_op),
      .es_i_alu_funct (es_i_alu_funct),
      .es_i_data_rs   (es_i_data_rs),
      .es_i_data_rt   (es_i_data_rt),
      .es_o_stall     (es_o_stall),
      .es_o_alu_value (es_o_alu_value),
      .es_o_ce        (es_o_ce),
      .es_o_done      (es_o_done)
   );

   // Free-running clock, period 10.
   initial es_clk = 1'b0;
   always #5 es_clk = ~es_clk;

   // Hard stop in case something upstream of the bounded waits hangs.
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   // Reference HI/LO from native wide arithmetic, independent of the shift/subtract datapath.
   function automatic void modelHiLo(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                     output logic [31:0] hi, output logic [31:0] lo);
      longint          p;
      longint unsigned pu;
      int              qs;
      int              rsi;
      hi = '0;
      lo = '0;
      case (f)
         FUNCT_MULT: begin
            p = longint'($signed(rs)) * longint'($signed(rt));
            {hi, lo} = p;
         end
         FUNCT_MULTU: begin
            pu = 64'(rs) * 64'(rt);
            {hi, lo} = pu;
         end
         FUNCT_DIV: begin
            if (rt == 32'h0) begin
               hi = rs;
               lo = 32'hFFFF_FFFF;
            end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
               hi = 32'h0;
               lo = 32'h8000_0000;
            end else begin
               qs  = $signed(rs) / $signed(rt);
               rsi = $signed(rs) % $signed(rt);
               lo  = qs;
               hi  = rsi;
            end
         end
         FUNCT_DIVU: begin
            if (rt == 32'h0) begin
               hi = rs;
               lo = 32'hFFFF_FFFF;
            end else begin
               lo = rs / rt;
               hi = rs % rt;
            end
         end
         default: ;
      endcase
   endfunction

   // Drive one instruction at a negedge and hold it until the unit is idle at the accept edge.
   task automatic applyStimulus(input logic ce, input logic [5:0] op, input logic [5:0] funct,
                                input logic [31:0] rs, input logic [31:0] rt, output int waits);
      @(negedge es_clk);
      es_i_ce        = ce;
      es_i_alu_op    = op;
      es_i_alu_funct = funct;
      es_i_data_rs   = rs;
      es_i_data_rt   = rt;
      waits          = 0;
      while (es_o_stall && waits < 100) begin
         waits++;
         @(negedge es_clk);
      end
      if (waits >= 100) begin
         errors++;
         checks++;
         $display("[TB] FAIL accept_timeout actual=stalled required=idle");
      end
      @(posedge es_clk);
      #1 es_i_ce = 1'b0;
   endtask

   task automatic waitIdle(output int cycles, output logic doneSeen);
      cycles = 0;
      @(negedge es_clk);
      while (es_o_stall && cycles < 100) begin
         cycles++;
         @(negedge es_clk);
      end
      doneSeen = es_o_done;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge es_clk);
   endtask

   task automatic expectValue(input string name, input logic [31:0] value);
      expNameQ.push_back(name);
      expValQ.push_back(value);
   endtask

   // Scoreboard: every es_o_ce cycle must match the oldest pending expectation.
   always @(negedge es_clk) begin
      if (es_o_done) doneCount++;
      if (es_o_ce) begin
         ceCount++;
         if (expValQ.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL unexpected_ce actual=0x%08h required=no_output", es_o_alu_value);
         end else begin
            checkOutput(expNameQ.pop_front(), es_o_alu_value, expValQ.pop_front());
         end
      end
   end

   initial begin
      int          w;
      int          cyc;
      logic        dn;
      int          doneBefore;
      int          ceBefore;
      logic [5:0]  rf;
      logic [31:0] rrs;
      logic [31:0] rrt;
      logic [31:0] mhi;
      logic [31:0] mlo;
      logic [5:0]  randFuncts[4];

      randFuncts[0] = FUNCT_MULT;
      randFuncts[1] = FUNCT_MULTU;
      randFuncts[2] = FUNCT_DIV;
      randFuncts[3] = FUNCT_DIVU;

      vecs.push_back('{FUNCT_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE});
      vecs.push_back('{FUNCT_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
      vecs.push_back('{FUNCT_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{FUNCT_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
      vecs.push_back('{FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
      vecs.push_back('{FUNCT_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001});
      vecs.push_back('{FUNCT_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
      vecs.push_back('{FUNCT_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
      vecs.push_back('{FUNCT_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
      vecs.push_back('{FUNCT_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
      vecs.push_back('{FUNCT_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
      for (int i = 0; i < 6; i++) begin
         rf  = randFuncts[$urandom_range(0, 3)];
         rrs = $urandom;
         rrt = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         modelHiLo(rf, rrs, rrt, mhi, mlo);
         vecs.push_back('{rf, rrs, rrt, mhi, mlo});
      end

      es_rst         = 1'b0;
      es_i_ce        = 1'b0;
      es_i_alu_op    = OP_RTYPE;
      es_i_alu_funct = FUNCT_ADD;
      es_i_data_rs   = '0;
      es_i_data_rt   = '0;
      idleCycles(3);
      checkOutput("reset_stall", 32'(es_o_stall), 32'h0);
      checkOutput("reset_ce", 32'(es_o_ce), 32'h0);
      checkOutput("reset_done", 32'(es_o_done), 32'h0);
      checkOutput("reset_value", es_o_alu_value, 32'h0);
      es_rst = 1'b1;

      // HI/LO cleared by reset.
      expectValue("reset_hi", 32'h0);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFHI, 32'h0, 32'h0, w);
      expectValue("reset_lo", 32'h0);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFLO, 32'h0, 32'h0, w);
      idleCycles(2);

      foreach (vecs[i]) begin
         doneBefore = doneCount;
         applyStimulus(1'b1, OP_RTYPE, vecs[i].funct, vecs[i].rs, vecs[i].rt, w);
         waitIdle(cyc, dn);
         checkOutput($sformatf("stall_cycles[%0d]", i), 32'(cyc), 32'd33);
         checkOutput($sformatf("done_after_stall[%0d]", i), 32'(dn), 32'h1);
         expectValue($sformatf("hi[%0d]", i), vecs[i].expHi);
         applyStimulus(1'b1, OP_RTYPE, FUNCT_MFHI, 32'h0, 32'h0, w);
         expectValue($sformatf("lo[%0d]", i), vecs[i].expLo);
         applyStimulus(1'b1, OP_RTYPE, FUNCT_MFLO, 32'h0, 32'h0, w);
         idleCycles(2);
         checkOutput($sformatf("done_pulses[%0d]", i), 32'(doneCount - doneBefore), 32'd1);
      end

      // MTHI/MTLO then back-to-back reads, no stall.
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MTHI, 32'h0000_1234, 32'h0, w);
      expectValue("mthi_mfhi", 32'h0000_1234);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFHI, 32'h0, 32'h0, w);
      checkOutput("mfhi_no_wait", 32'(w), 32'h0);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MTLO, 32'hCAFE_0001, 32'h0, w);
      expectValue("mtlo_mflo", 32'hCAFE_0001);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFLO, 32'h0, 32'h0, w);
      checkOutput("mflo_no_wait", 32'(w), 32'h0);
      idleCycles(2);

      // Ignored instructions: ALU functs, ce low, non-RTYPE opcode.
      ceBefore   = ceCount;
      doneBefore = doneCount;
      applyStimulus(1'b1, OP_RTYPE, FUNCT_ADD, 32'h5, 32'h6, w);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_SUB, 32'h5, 32'h6, w);
      applyStimulus(1'b0, OP_RTYPE, FUNCT_MFHI, 32'h0, 32'h0, w);
      applyStimulus(1'b0, OP_RTYPE, FUNCT_MULT, 32'h3, 32'h3, w);
      applyStimulus(1'b1, 6'h08, FUNCT_MTHI, 32'h9999, 32'h0, w);
      idleCycles(2);
      checkOutput("ignored_no_stall", 32'(es_o_stall), 32'h0);
      checkOutput("ignored_no_ce", 32'(ceCount - ceBefore), 32'h0);
      checkOutput("ignored_no_done", 32'(doneCount - doneBefore), 32'h0);
      expectValue("ignored_hi_kept", 32'h0000_1234);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFHI, 32'h0, 32'h0, w);
      idleCycles(2);

      // MFLO held behind DIVU 9/4 until the result lands.
      doneBefore = doneCount;
      applyStimulus(1'b1, OP_RTYPE, FUNCT_DIVU, 32'd9, 32'd4, w);
      expectValue("held_mflo", 32'd2);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFLO, 32'h0, 32'h0, w);
      checkOutput("held_mflo_wait", 32'(w), 32'd33);
      checkOutput("held_done_before_accept", 32'(doneCount - doneBefore), 32'd1);
      expectValue("held_mfhi", 32'd1);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFHI, 32'h0, 32'h0, w);
      idleCycles(2);

      // Operands changing during the stall must not matter.
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MULTU, 32'd6, 32'd7, w);
      @(negedge es_clk);
      es_i_data_rs = 32'hDEAD_BEEF;
      es_i_data_rt = 32'h1234_5678;
      waitIdle(cyc, dn);
      expectValue("latched_lo", 32'd42);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFLO, 32'h0, 32'h0, w);
      idleCycles(2);

      // Reset asserted mid-MULT aborts it.
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MULT, 32'd3, 32'd5, w);
      idleCycles(10);
      doneBefore = doneCount;
      es_rst = 1'b0;
      @(negedge es_clk);
      es_rst = 1'b1;
      checkOutput("abort_stall_low", 32'(es_o_stall), 32'h0);
      idleCycles(40);
      checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'h0);
      expectValue("abort_lo", 32'h0);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFLO, 32'h0, 32'h0, w);
      expectValue("abort_hi", 32'h0);
      applyStimulus(1'b1, OP_RTYPE, FUNCT_MFHI, 32'h0, 32'h0, w);
      idleCycles(3);

      checkOutput("scoreboard_drained", 32'(expValQ.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
